// File: rtl/pc_gen_ras_pkg.sv
// Shared definitions for the fetch PC generator.
//   next_pc_sel_e : source chosen for the next fetch PC, lowest to highest priority
//   PC_INC        : sequential fetch increment in bytes
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ      = 3'd0,
    SEL_JAL      = 3'd1,
    SEL_RAS      = 3'd2,
    SEL_HOLD     = 3'd3,
    SEL_REDIRECT = 3'd4,
    SEL_TRAP     = 3'd5
  } next_pc_sel_e;

  localparam int unsigned PC_INC = 32'd4;

endpackage

// File: rtl/pc_gen_ras_ras_stack.sv
// Circular return-address stack.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data one slot above the current top
//   pop        : discard the top entry (ignored when empty)
//   push + pop : on a non-empty stack the top entry is replaced in place
//   push_data  : return address to store
//   top        : current top entry
//   count      : number of valid entries, saturating at DEPTH
//   empty      : count is zero
// When full, a push wraps onto the oldest entry; the count stays at DEPTH.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] top_ptr_inc;
  logic [CNT_W-1:0] cnt;

  // Pointer wraps modulo DEPTH because DEPTH is a power of two.
  assign top_ptr_inc = top_ptr + PTR_W'(1);
  assign empty       = (cnt == CNT_W'(0));
  assign top         = mem[top_ptr];
  assign count       = cnt;

  // Stack storage, top pointer and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= PTR_W'(0);
      cnt     <= CNT_W'(0);
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= WIDTH'(0);
      end
    end else if (push && pop && !empty) begin
      // Coroutine swap: the popped slot is reused for the new return address.
      mem[top_ptr] <= push_data;
    end else if (push) begin
      mem[top_ptr_inc] <= push_data;
      top_ptr          <= top_ptr_inc;
      if (cnt != CNT_W'(DEPTH)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PTR_W'(1);
      cnt     <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch PC generator with return-address-stack prediction.
//   clk, rst       : clock, asynchronous active-high reset
//   stall_i        : hold PC and RAS
//   trap_i         : redirect to TRAP_VECTOR (highest priority)
//   redirect_i     : EX-resolved redirect to redirect_pc_i (bit 0 cleared)
//   redirect_pc_i  : redirect target
//   pd_jal_i       : predecoded JAL, target pc_o + pd_imm_i
//   pd_call_i      : predecoded call, pushes pc_o + 4
//   pd_ret_i       : predecoded return, pops RAS top as next PC
//   pd_imm_i       : sign-extended J-immediate
//   pc_o           : registered fetch PC
//   pc_plus4_o     : pc_o + 4
//   pred_ras_o     : next PC is taken from the RAS this cycle
//   ras_count_o    : valid RAS entries
// Trap and redirect do not repair the RAS; its contents survive them untouched.
module pc_gen_ras
  import pc_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'h0000_0000),
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = PC_WIDTH'(32'h0000_0100)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_i,
  input  logic                          trap_i,
  input  logic                          redirect_i,
  input  logic [PC_WIDTH-1:0]           redirect_pc_i,
  input  logic                          pd_jal_i,
  input  logic                          pd_call_i,
  input  logic                          pd_ret_i,
  input  logic [PC_WIDTH-1:0]           pd_imm_i,
  output logic [PC_WIDTH-1:0]           pc_o,
  output logic [PC_WIDTH-1:0]           pc_plus4_o,
  output logic                          pred_ras_o,
  output logic [$clog2(RAS_DEPTH):0]    ras_count_o
);

  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty;
  logic                ras_upd;
  logic                ras_push;
  logic                ras_pop;
  next_pc_sel_e        sel;

  assign pc_plus4   = pc_r + PC_WIDTH'(PC_INC);
  assign pc_o       = pc_r;
  assign pc_plus4_o = pc_plus4;

  // The RAS only moves on a plain, unstalled fetch.
  assign ras_upd  = !trap_i && !redirect_i && !stall_i;
  assign ras_push = ras_upd && pd_call_i;
  assign ras_pop  = ras_upd && pd_ret_i && !ras_empty;

  // Next-PC source selection in priority order.
  always_comb begin
    sel = SEL_SEQ;
    if (trap_i) begin
      sel = SEL_TRAP;
    end else if (redirect_i) begin
      sel = SEL_REDIRECT;
    end else if (stall_i) begin
      sel = SEL_HOLD;
    end else if (pd_ret_i && !ras_empty) begin
      sel = SEL_RAS;
    end else if (pd_jal_i) begin
      sel = SEL_JAL;
    end else begin
      sel = SEL_SEQ;
    end
  end

  // Next-PC value for the chosen source.
  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_TRAP:     next_pc = TRAP_VECTOR;
      // Masking rather than slicing keeps the target halfword-aligned.
      SEL_REDIRECT: next_pc = redirect_pc_i & ~PC_WIDTH'(1);
      SEL_HOLD:     next_pc = pc_r;
      SEL_RAS:      next_pc = ras_top;
      SEL_JAL:      next_pc = pc_r + pd_imm_i;
      SEL_SEQ:      next_pc = pc_plus4;
      default:      next_pc = pc_plus4;
    endcase
  end

  assign pred_ras_o = (sel == SEL_RAS) && !rst;

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_VECTOR;
    end else begin
      pc_r <= next_pc;
    end
  end

  ras_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .count     (ras_count_o),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_gen_ras.sv
// Scoreboard bench for pc_gen_ras: directed scenarios then random stimulus,
// checked against a queue-based model of the fetch PC and return stack.
module tb_pc_gen_ras;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        trap_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        pd_jal_i;
  logic        pd_call_i;
  logic        pd_ret_i;
  logic [31:0] pd_imm_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pred_ras_o;
  logic [2:0]  ras_count_o;

  pc_gen_ras dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .trap_i        (trap_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pd_jal_i      (pd_jal_i),
    .pd_call_i     (pd_call_i),
    .pd_ret_i      (pd_ret_i),
    .pd_imm_i      (pd_imm_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .pred_ras_o    (pred_ras_o),
    .ras_count_o   (ras_count_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    int          cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        pred_pre;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  // pred_ras_o is combinational; capture it just before the edge it predicts.
  always @(negedge clk) begin
    #4;
    pred_pre = pred_ras_o;
  end

  // Monitor: after each edge, compare the DUT against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", pc_o, e.pc);
      check("pc_plus4", pc_plus4_o, e.pc + 32'd4);
      check("pred_ras", {31'd0, pred_pre}, {31'd0, e.pred});
      check("ras_count", {29'd0, ras_count_o}, 32'(e.cnt));
    end
  end

  task automatic set_idle();
    trap_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; stall_i = 1'b0;
    pd_jal_i = 1'b0; pd_call_i = 1'b0; pd_ret_i = 1'b0; pd_imm_i = 32'd0;
  endtask

  // Called at a falling edge: drive one fetch cycle, predict, wait a cycle.
  task automatic step(input logic trap, input logic redir, input logic [31:0] rpc,
                      input logic stall, input logic jal, input logic call,
                      input logic ret, input logic [31:0] imm);
    exp_t        e;
    logic        plain;
    logic [31:0] npc;
    trap_i = trap; redirect_i = redir; redirect_pc_i = rpc; stall_i = stall;
    pd_jal_i = jal; pd_call_i = call; pd_ret_i = ret; pd_imm_i = imm;
    plain  = !trap && !redir && !stall;
    e.pred = plain && ret && (m_ras.size() > 0);
    if (trap)        npc = 32'h0000_0100;
    else if (redir)  npc = {rpc[31:1], 1'b0};
    else if (stall)  npc = m_pc;
    else if (e.pred) npc = m_ras[m_ras.size()-1];
    else if (jal)    npc = m_pc + imm;
    else             npc = m_pc + 32'd4;
    if (plain) begin
      if (call && ret && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = m_pc + 32'd4;
      end else if (call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (ret && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    m_pc  = npc;
    e.pc  = npc;
    e.cnt = m_ras.size();
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic go_to(input logic [31:0] target);
    step(1'b0, 1'b1, target, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    set_idle();
    rst  = 1'b1;
    m_pc = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_pc", pc_o, 32'd0);
    check("reset_count", {29'd0, ras_count_o}, 32'd0);
    check("reset_pred", {31'd0, pred_ras_o}, 32'd0);
    rst = 1'b0;

    // Sequential fetch from reset.
    repeat (3) idle();

    // JAL call then matching return.
    go_to(32'h10);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Five nested calls overflow a 4-deep stack; five returns, last one empty.
    go_to(32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);

    // Stall blocks call; redirect overrides stall and clears bit 0.
    go_to(32'h20);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h81, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

    // Trap wins over redirect and JAL, RAS untouched.
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8);
    step(1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    // Coroutine swap on non-empty stack, then on empty stack.
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);

    // Address wrap, then asynchronous reset mid-stream with three entries.
    go_to(32'hFFFF_FFFC);
    idle();
    go_to(32'h200);
    while (m_ras.size() < 3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40);
    check("count_before_rst", {29'd0, ras_count_o}, 32'(m_ras.size()));
    set_idle();
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", pc_o, 32'd0);
    check("async_rst_count", {29'd0, ras_count_o}, 32'd0);
    check("async_rst_pred", {31'd0, pred_ras_o}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    m_pc = 32'd0;
    m_ras.delete();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFC) : $urandom);
    end
    set_idle();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
